word_scroll: RTL

- Sequential front end for the five-digit seven-segment word display on the DE2 board.
- Holds an 8-character message ring (default "HELLO" + 3 blanks) and drives five active-low 7-segment codes p..t.
- Shows a 5-character window that scrolls left or right at a prescaled rate, with pause, dash override and a paused-only character load port.

---
 rtl/word_scroll_if.sv | 19 +
 rtl/word_scroll.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/word_scroll_if.sv
// word_scroll character load port.
// Valid/ready write channel into the message ring.
interface word_scroll_if;
  logic       ld_valid;
  logic [6:0] ld_data;
  logic       ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/word_scroll.sv
// word_scroll: 8-char message ring shown through a 5-digit
// scrolling window of active-low seven-segment codes.
module word_scroll #(
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         dir,
  input  logic         dash,
  word_scroll_if.slave ld,
  output logic [6:0]   p,
  output logic [6:0]   q,
  output logic [6:0]   r,
  output logic [6:0]   s,
  output logic [6:0]   t,
  output logic         wrap
);

  localparam logic [6:0] SEG_H   = 7'b0001001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_O   = 7'b1000000;
  localparam logic [6:0] SEG_BLK = 7'b1111111;
  localparam logic [6:0] SEG_DSH = 7'b0111111;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    PAUSE,
    RUN,
    DASH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic [2:0]       wr_idx;
  logic [6:0]       msg [8];
  logic [6:0]       win [5];
  logic             wrap_pend;
  logic             step;
  logic             step_wrap;
  logic             wr_en;

  function automatic logic [6:0] dflt(input logic [2:0] i);
    logic [6:0] c;
    case (i)
      3'd0:    c = SEG_H;
      3'd1:    c = SEG_E;
      3'd2:    c = SEG_L;
      3'd3:    c = SEG_L;
      3'd4:    c = SEG_O;
      default: c = SEG_BLK;
    endcase
    return c;
  endfunction

  // Mode register: PAUSE / RUN / DASH.
  always_ff @(posedge clk) begin
    if (rst) state <= PAUSE;
    else     state <= state_nxt;
  end

  // Mode transitions plus step and load strobes.
  always_comb begin
    state_nxt   = state;
    step        = 1'b0;
    step_wrap   = 1'b0;
    wr_en       = 1'b0;
    ld.ld_ready = (state == PAUSE);
    ptr_nxt     = dir ? ptr - 3'd1 : ptr + 3'd1;
    if (dash) begin
      state_nxt = DASH;
    end else begin
      case (state)
        PAUSE:   if (run)  state_nxt = RUN;
        RUN:     if (!run) state_nxt = PAUSE;
        DASH:    state_nxt = run ? RUN : PAUSE;
        default: state_nxt = PAUSE;
      endcase
    end
    if (state == RUN && div_cnt == DIV_LAST) begin
      step      = 1'b1;
      step_wrap = dir ? (ptr == 3'd0) : (ptr == 3'd7);
    end
    wr_en = ld.ld_valid && (state == PAUSE);
  end

  // Five ring slots starting at ptr, indices wrapping mod 8.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      logic [2:0] idx;
      idx    = ptr + 3'(i);
      win[i] = msg[idx];
    end
  end

  // Divider, pointer, ring, and registered digit/wrap outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      ptr       <= '0;
      wr_idx    <= '0;
      wrap_pend <= 1'b0;
      wrap      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        msg[i] <= dflt(3'(i));
      end
      p <= SEG_H;
      q <= SEG_E;
      r <= SEG_L;
      s <= SEG_L;
      t <= SEG_O;
    end else begin
      // wrap trails the step by one so it lines up with the digits.
      wrap_pend <= step_wrap;
      wrap      <= wrap_pend;
      if (state == RUN) begin
        div_cnt <= step ? '0 : div_cnt + DIV_W'(1);
      end
      if (step) ptr <= ptr_nxt;
      if (wr_en) begin
        msg[wr_idx] <= ld.ld_data;
        wr_idx      <= wr_idx + 3'd1;
      end
      if (state == DASH) begin
        p <= SEG_DSH;
        q <= SEG_DSH;
        r <= SEG_DSH;
        s <= SEG_DSH;
        t <= SEG_DSH;
      end else begin
        p <= win[0];
        q <= win[1];
        r <= win[2];
        s <= win[3];
        t <= win[4];
      end
    end
  end

endmodule
